// File: rtl/div_requester_if.sv
// Divider request/response bus between div_requester and the long-division divider.
//   master (requester): drives div_en, div_a, div_b, div_is_signed;
//                       receives div_ready, div_q, div_r
//   slave  (divider)  : the mirror image
// div_a/div_b/div_is_signed are read combinationally by the divider for sign
// correction, so the master keeps them stable for the whole operation.
interface div_requester_if;
  logic        div_en;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_is_signed;
  logic        div_ready;
  logic [31:0] div_q;
  logic [31:0] div_r;

  modport master (
    output div_en, div_a, div_b, div_is_signed,
    input  div_ready, div_q, div_r
  );

  modport slave (
    input  div_en, div_a, div_b, div_is_signed,
    output div_ready, div_q, div_r
  );
endinterface

// File: rtl/div_requester.sv
// Execute-stage front end for RISC-V DIV/DIVU/REM/REMU.
// Issues one operation at a time to the long-division divider, stalls the
// pipeline while it runs, and keeps a one-entry result cache so that the
// matching DIV/REM partner on identical operands completes in one cycle.
// Ports:
//   clk, nrst      clock, synchronous active-low reset
//   req            divide request, held with op/rs1/rs2 stable until done
//   op             [0]=unsigned, [1]=remainder
//   rs1, rs2       dividend, divisor
//   flush          squash the current request
//   busy           high whenever the FSM is not idle
//   done           one-cycle completion pulse
//   result         selected quotient/remainder, held until the next done
//   div_bus        divider handshake (master side)
module div_requester (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   req,
  input  logic [1:0]             op,
  input  logic [31:0]            rs1,
  input  logic [31:0]            rs2,
  input  logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            result,
  div_requester_if.master        div_bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    RESP
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        signed_reg;
  logic        rem_sel;

  logic        cache_valid;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic        cache_signed;
  logic [31:0] cache_q;
  logic [31:0] cache_r;

  logic        hit;
  logic        accept_hit;
  logic        accept_miss;
  logic        cache_wr;
  logic        load_div;

  // The divider sees the registered operands directly; they only move on a
  // miss-accept, which keeps them stable from ISSUE through div_ready.
  assign div_bus.div_a         = a_reg;
  assign div_bus.div_b         = b_reg;
  assign div_bus.div_is_signed = signed_reg;

  // Signedness is part of the tag: DIV and DIVU on the same bits differ.
  assign hit = cache_valid && (rs1 == cache_a) && (rs2 == cache_b) &&
               ((!op[0]) == cache_signed);

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. A flush that arrives once the divider has
  // been started cannot cancel it, so the FSM drains the divider and still
  // captures the result into the cache (but never reports it as done).
  always_comb begin
    next_state     = state;
    accept_hit     = 1'b0;
    accept_miss    = 1'b0;
    cache_wr       = 1'b0;
    load_div       = 1'b0;
    busy           = (state != IDLE);
    done           = (state == RESP);
    div_bus.div_en = (state == ISSUE);
    case (state)
      IDLE: begin
        if (req && !flush) begin
          if (hit) begin
            accept_hit = 1'b1;
            next_state = RESP;
          end else begin
            accept_miss = 1'b1;
            next_state  = ISSUE;
          end
        end
      end
      ISSUE: begin
        next_state = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (div_bus.div_ready) begin
          cache_wr = 1'b1;
          if (flush) begin
            next_state = IDLE;
          end else begin
            load_div   = 1'b1;
            next_state = RESP;
          end
        end else if (flush) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (div_bus.div_ready) begin
          cache_wr   = 1'b1;
          next_state = IDLE;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand, result and cache registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      signed_reg   <= 1'b0;
      rem_sel      <= 1'b0;
      result       <= '0;
      cache_valid  <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_signed <= 1'b0;
      cache_q      <= '0;
      cache_r      <= '0;
    end else begin
      if (accept_miss) begin
        a_reg      <= rs1;
        b_reg      <= rs2;
        signed_reg <= !op[0];
        rem_sel    <= op[1];
      end
      if (accept_hit) begin
        result <= op[1] ? cache_r : cache_q;
      end
      if (load_div) begin
        result <= rem_sel ? div_bus.div_r : div_bus.div_q;
      end
      if (cache_wr) begin
        cache_valid  <= 1'b1;
        cache_a      <= a_reg;
        cache_b      <= b_reg;
        cache_signed <= signed_reg;
        cache_q      <= div_bus.div_q;
        cache_r      <= div_bus.div_r;
      end
    end
  end

endmodule

// File: tb/tb_div_requester.sv
// Self-checking bench for div_requester. Contains a behavioural divider
// (PRECHECK + 32 DIVIDE cycles, one-cycle early exit for divide-by-zero and
// signed overflow) and an arithmetic reference model of the result cache.
module tb_div_requester;

  logic        clk;
  logic        nrst;
  logic        req;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int failures;
  int en_count;

  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_signed;

  logic [31:0] dv_q;
  logic [31:0] dv_r;
  logic        dv_ready;
  int          dv_cnt;
  logic [63:0] dv_qr;

  div_requester_if dif ();

  assign dif.div_ready = dv_ready;
  assign dif.div_q     = dv_q;
  assign dif.div_r     = dv_r;

  div_requester dut (
    .clk     (clk),
    .nrst    (nrst),
    .req     (req),
    .op      (op),
    .rs1     (rs1),
    .rs2     (rs2),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .div_bus (dif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V divide semantics as {quotient, remainder}.
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic isSpecial(input logic [31:0] a, input logic [31:0] b,
                                     input logic sgn);
    return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Behavioural divider: start on div_en, ready after PRECHECK (special
  // cases) or after PRECHECK plus 32 DIVIDE cycles.
  always @(posedge clk) begin
    if (!nrst) begin
      dv_cnt   <= 0;
      dv_ready <= 1'b0;
      dv_q     <= '0;
      dv_r     <= '0;
    end else begin
      dv_ready <= 1'b0;
      if (dif.div_en) begin
        dv_qr = refDiv(dif.div_a, dif.div_b, dif.div_is_signed);
        dv_q <= dv_qr[63:32];
        dv_r <= dv_qr[31:0];
        if (isSpecial(dif.div_a, dif.div_b, dif.div_is_signed)) begin
          dv_ready <= 1'b1;
        end else begin
          dv_cnt <= 33;
        end
      end else if (dv_cnt != 0) begin
        dv_cnt <= dv_cnt - 1;
        if (dv_cnt == 1) dv_ready <= 1'b1;
      end
    end
  end

  // Counts divider start pulses.
  always @(posedge clk) begin
    if (nrst && dif.div_en) en_count++;
  end

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete request from the IDLE accept cycle; expected latency,
  // result and div_en count come from the reference cache model.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    logic        sgn;
    logic        hit;
    logic [63:0] qr;
    logic [31:0] exp;
    int          lat;
    int          cyc;
    int          base;
    sgn  = !o[0];
    hit  = m_valid && a == m_a && b == m_b && sgn == m_signed;
    qr   = refDiv(a, b, sgn);
    exp  = o[1] ? qr[31:0] : qr[63:32];
    lat  = hit ? 1 : (isSpecial(a, b, sgn) ? 3 : 36);
    base = en_count;
    req  = 1'b1;
    op   = o;
    rs1  = a;
    rs2  = b;
    cyc  = 0;
    do begin
      waitCycle();
      cyc++;
      if (cyc == 1 && !hit) begin
        checkOutput("issue_busy", {31'd0, busy}, 32'd1);
        checkOutput("div_a", dif.div_a, a);
        checkOutput("div_b", dif.div_b, b);
        checkOutput("div_is_signed", {31'd0, dif.div_is_signed}, {31'd0, sgn});
      end
    end while (!done && cyc < 80);
    checkOutput("latency", 32'(cyc), 32'(lat));
    checkOutput("result", result, exp);
    checkOutput("div_en_pulses", 32'(en_count - base), hit ? 32'd0 : 32'd1);
    req = 1'b0;
    waitCycle();
    checkOutput("done_single", {31'd0, done}, 32'd0);
    checkOutput("idle_after", {31'd0, busy}, 32'd0);
    checkOutput("result_held", result, exp);
    if (!hit) begin
      m_valid  = 1'b1;
      m_a      = a;
      m_b      = b;
      m_signed = sgn;
    end
  endtask

  // DIVU 1000/3 flushed at cycle 10; reissue is held off during DRAIN and
  // then served from the cache filled by the drained division.
  task automatic flushScenario();
    int   cyc;
    int   base;
    logic seen_done;
    base = en_count;
    req  = 1'b1;
    op   = 2'b01;
    rs1  = 32'd1000;
    rs2  = 32'd3;
    cyc  = 0;
    repeat (10) begin
      waitCycle();
      cyc++;
    end
    flush = 1'b1;
    req   = 1'b0;
    waitCycle();
    cyc++;
    flush = 1'b0;
    req   = 1'b1;
    seen_done = 1'b0;
    while (busy && cyc < 80) begin
      if (done) seen_done = 1'b1;
      waitCycle();
      cyc++;
    end
    checkOutput("drain_busy_end", 32'(cyc), 32'd36);
    checkOutput("drain_no_done", {31'd0, seen_done}, 32'd0);
    checkOutput("drain_div_en", 32'(en_count - base), 32'd1);
    m_valid  = 1'b1;
    m_a      = 32'd1000;
    m_b      = 32'd3;
    m_signed = 1'b0;
    waitCycle();
    checkOutput("reissue_done", {31'd0, done}, 32'd1);
    checkOutput("reissue_result", result, 32'h0000_014D);
    checkOutput("reissue_div_en", 32'(en_count - base), 32'd1);
    req = 1'b0;
    waitCycle();
    checkOutput("reissue_idle", {31'd0, busy | done}, 32'd0);
  endtask

  // Reset asserted at cycle 20 of a miss.
  task automatic resetScenario();
    req = 1'b1;
    op  = 2'b01;
    rs1 = 32'h00AB_CDEF;
    rs2 = 32'd13;
    repeat (20) waitCycle();
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    req  = 1'b0;
    waitCycle();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_div_en", {31'd0, dif.div_en}, 32'd0);
    checkOutput("rst_div_a", dif.div_a, 32'd0);
    checkOutput("rst_div_b", dif.div_b, 32'd0);
    checkOutput("rst_div_signed", {31'd0, dif.div_is_signed}, 32'd0);
    nrst    = 1'b1;
    m_valid = 1'b0;
    applyStimulus(2'b01, 32'h00AB_CDEF, 32'd13);
  endtask

  initial begin
    logic [31:0] pool_a [4];
    logic [31:0] pool_b [4];
    logic [31:0] ra;
    logic [31:0] rb;
    checks   = 0;
    failures = 0;
    en_count = 0;
    m_valid  = 1'b0;
    m_a      = '0;
    m_b      = '0;
    m_signed = 1'b0;
    nrst  = 1'b0;
    req   = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    rs1   = '0;
    rs2   = '0;
    repeat (2) waitCycle();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_div_en", {31'd0, dif.div_en}, 32'd0);
    checkOutput("reset_div_a", dif.div_a, 32'd0);
    nrst = 1'b1;
    waitCycle();

    $display("[TB] directed sequences");
    applyStimulus(2'b01, 32'd100, 32'd7);
    applyStimulus(2'b11, 32'd100, 32'd7);
    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(2'b00, 32'd5, 32'd0);
    applyStimulus(2'b10, 32'd5, 32'd0);
    applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    flushScenario();
    resetScenario();

    $display("[TB] randomized sequences");
    pool_a[0] = 32'h8000_0000;
    pool_a[1] = 32'hFFFF_FFF9;
    pool_a[2] = 32'd100;
    pool_b[0] = 32'd0;
    pool_b[1] = 32'hFFFF_FFFF;
    pool_b[2] = 32'd7;
    ra = 32'd1;
    rb = 32'd1;
    for (int i = 0; i < 24; i++) begin
      pool_a[3] = $urandom;
      pool_b[3] = $urandom_range(1, 1000);
      if ($urandom_range(0, 1) == 0) begin
        ra = pool_a[$urandom_range(0, 3)];
        rb = pool_b[$urandom_range(0, 3)];
      end
      applyStimulus(2'($urandom_range(0, 3)), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
